apb4_reg_native_bridge: RTL

Parametrised APB4 completer that converts APB transfers into single-cycle register-native requests (req_vld/ack_vld handshake) toward a generated register block. Successor to the basic APB-to-native bridge. Adds APB4 byte strobes and pprot-based access filtering, alignment checking, a response-timeout watchdog, and a selectable registered-response mode. Sits between the APB interconnect and one register slice.

---
 rtl/apb4_reg_native_bridge_pkg.sv | 21 ++
 rtl/apb4_reg_native_bridge_if.sv | 29 ++
 rtl/apb4_reg_native_bridge_timeout_cnt.sv | 30 +++
 rtl/apb4_reg_native_bridge.sv | 123 ++++++++++++
 4 files changed

// File: rtl/apb4_reg_native_bridge_pkg.sv
// Shared types and helpers for the APB4 to register-native bridge.
// Holds the FSM state encoding, width helpers and the APB4 privilege bit index.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bridge_state_e;

    localparam int PROT_PRIV = 0;

    function automatic int STRB_W(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int ALIGN_LSB(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb4_reg_native_bridge_if.sv
// APB4 completer-side bus bundle for the register-native bridge.
// The master modport is the interconnect side, the slave modport is the bridge side.
interface apb4_reg_native_bridge_if
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 32
);
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [STRB_W(DATA_WIDTH)-1:0] pstrb;
    logic [2:0]                    pprot;
    logic                          pready;
    logic [DATA_WIDTH-1:0]         prdata;
    logic                          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_reg_native_bridge_timeout_cnt.sv
// Saturating WAIT-cycle counter; expire pulses when the last allowed WAIT cycle
// passes without an ack. Tied off to expire=0 when TIMEOUT_CYCLES==0.
module bridge_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_V = LAST_I[CNT_W-1:0];

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && en && (r_cnt == LAST_V);
endmodule

// File: rtl/apb4_reg_native_bridge.sv
// APB4 completer that turns each transfer into one single-cycle native register request,
// with strobe/protection filtering, alignment check, response watchdog and optional registered response.
module apb4_reg_native_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit REG_RESP       = 1'b0,
    parameter bit ALIGN_CHECK    = 1'b1,
    parameter bit PRIV_ONLY      = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    apb4_reg_native_bridge_if.slave       apb,
    output logic                          req_vld,
    output logic                          wr_en,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [STRB_W(DATA_WIDTH)-1:0] wr_strb,
    input  logic                          ack_vld,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          err,
    output logic                          timeout_pulse
);
    localparam int LSB_W = ALIGN_LSB(DATA_WIDTH);

    bridge_state_e         r_state;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_err;

    logic w_setup, w_misalign, w_unpriv, w_reject, w_accept;
    logic w_direct, w_tmr_clr, w_tmr_en, w_expire;

    generate
        if (ALIGN_CHECK && (LSB_W > 0)) begin : g_align
            assign w_misalign = |apb.paddr[LSB_W-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_setup  = (r_state == IDLE) && apb.psel && !apb.penable;
    assign w_unpriv = PRIV_ONLY && !apb.pprot[PROT_PRIV];
    assign w_reject = w_misalign || w_unpriv;
    assign w_accept = w_setup && !w_reject;

    // Native side is combinational so the request lands in the APB setup cycle itself.
    assign req_vld = w_accept;
    assign wr_en   = w_accept && apb.pwrite;
    assign rd_en   = w_accept && !apb.pwrite;
    assign addr    = w_accept ? apb.paddr : '0;
    assign wr_data = w_accept ? apb.pwdata : '0;
    assign wr_strb = (w_accept && apb.pwrite) ? apb.pstrb : '0;

    assign w_direct    = !REG_RESP && (r_state == WAIT) && ack_vld;
    assign apb.pready  = (r_state == RESP) || w_direct;
    assign apb.prdata  = (r_state == RESP) ? r_rd  : (w_direct ? rd_data : '0);
    assign apb.pslverr = (r_state == RESP) ? r_err : (w_direct && err);

    // An ack in WAIT suppresses the count, so a coinciding expiry can never fire.
    assign w_tmr_clr = w_accept && !ack_vld;
    assign w_tmr_en  = (r_state == WAIT) && !ack_vld;

    bridge_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expire (w_expire)
    );

    assign timeout_pulse = w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        if (w_reject) begin
                            r_state <= RESP;
                            r_rd    <= '0;
                            r_err   <= 1'b1;
                        end else if (ack_vld) begin
                            r_state <= RESP;
                            r_rd    <= apb.pwrite ? '0 : rd_data;
                            r_err   <= err;
                        end else begin
                            r_state <= WAIT;
                            r_wr    <= apb.pwrite;
                        end
                    end
                end
                WAIT: begin
                    if (ack_vld) begin
                        if (REG_RESP) begin
                            r_state <= RESP;
                            r_rd    <= r_wr ? '0 : rd_data;
                            r_err   <= err;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_expire) begin
                        r_state <= RESP;
                        r_rd    <= '0;
                        r_err   <= 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
